fwd_bypass_unit: RTL
====================

# fwd_bypass_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core, sitting between ID and EX. It tracks destination registers of the DEPTH youngest in-flight instructions in a shift-register scoreboard, selects each of NSRC source operands from the register file or the youngest matching stage result, and registers the chosen operands into the ID/EX boundary. It raises a one-cycle stall on load-use dependences and injects a bubble. It replaces the fixed two-bit, three-input forwarding mux.

## Interface
- XLEN, 32, datapath width
- AW, 5, register index width (register 0 is hard-wired zero)
- NSRC, 2, source operands per instruction (rs, rt, ...)
- DEPTH, 3, tracked stages after ID (0 = EX, 1 = MEM, 2 = WB); DEPTH ≥ 2

- clk  in  1  pipeline clock
- clrn  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 freezes all state
- flush  in  1  kill ID instruction (bubble into stage 0)
- id_valid  in  1  ID holds a real instruction
- id_src  in  NSRC*AW  source indices, source i at bits [i*AW +: AW]
- id_rf_data  in  NSRC*XLEN  register-file read data per source
- id_wreg  in  1  ID instruction writes a register
- id_rd  in  AW  ID destination index
- id_m2reg  in  1  ID instruction is a load
- stage_data  in  DEPTH*XLEN  result currently held by stage k (EX ALU r, MEM mqb, WB data)
- stall  out  1  combinational load-use stall; ID and IF must hold
- ex_valid  out  1  registered; EX holds a real instruction
- ex_operand  out  NSRC*XLEN  registered forwarded operands
- ex_fwd_sel  out  NSRC*SELW  registered select per source (0 = RF, k+1 = stage k)
- stall_count, fwd_count  out  32 each  performance counters (see Configuration)

## Operation
- Scoreboard entry per stage: valid, wreg, m2reg, rd. A stage k matches source i when valid & wreg & rd == id_src[i] & id_src[i] != 0.
- Per source, priority: lowest matching k wins (youngest); no match → id_rf_data. Source index 0 always selects RF (reads 0).
- Load-use: stage 0 matches with m2reg = 1 → stall = id_valid. Stage ≥ 1 loads forward normally from stage_data.
- On en: scoreboard shifts k → k+1 (oldest discarded); stage 0 loads ID fields if id_valid & ~stall & ~flush, else bubble (valid = 0). ex_valid follows stage 0 valid; ex_operand/ex_fwd_sel capture the selections (zeros on bubble).
- en = 0: no state changes; stall still evaluated.
- flush and stall together: flush wins (bubble, counters count the stall only if id_valid).

## Timing
- stall: combinational, same cycle as ID inputs.
- Operand latency: 1 cycle (ID inputs → ex_operand on next clk edge with en).
- Load-use stall lasts exactly 1 cycle: the load moves to stage 1 and its data forwards from stage_data[1].
- Reset (any time, async): all scoreboard valid = 0, ex_valid = 0, ex_operand = 0, ex_fwd_sel = 0, counters = 0; stall = 0 until a valid ID instruction appears.
- WB same-cycle write: stage DEPTH-1 forwarding covers RF write-before-read gaps; no RF write-through assumed.

## Configuration
- FWD_PERF_CNT_EN defined: stall_count increments on each en cycle with stall = 1; fwd_count increments by the number of sources with ex_fwd_sel != 0 captured that cycle; both saturate at 0xFFFFFFFF.
- Undefined: counters absent, both outputs tied to 0.

## Structure
- Package fwd_pkg: SELW = $clog2(DEPTH+1), select constants FWD_SEL_RF = 0 and FWD_SEL_STAGE base = 1, scoreboard entry struct type.
- Sub-module fwd_src_sel: one per source (generate loop); priority comparator over scoreboard plus data mux; outputs select, data, load_hazard.

## Test plan
- add $3 in EX (stage_data[0]=0x11), ID reads $3 → ex_operand[0]=0x11, ex_fwd_sel[0]=1, no stall.
- $3 written in both EX (0x22) and MEM (0x33), ID reads $3 → 0x22 (youngest wins).
- lw $4 in EX, ID reads $4 → stall=1 one cycle, bubble in EX; next cycle stage_data[1]=0xCAFE forwarded, sel=2.
- ID reads $0 while EX writes $0 with 0x55 → operand 0, sel 0.
- clrn low mid-stall with lw in EX → all outputs 0, stall 0 after release with id_valid=0; FWD_PERF_CNT_EN: counters 0.
- en=0 for 3 cycles with pending forward → ex_operand unchanged; flush with stall → bubble, stall_count +1.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding unit: select encoding,
// select-width helper and the scoreboard entry layout.
package fwd_pkg;

    localparam int FWD_DEPTH     = 3;
    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_STAGE = 1;

    // rd is stored wide enough for any supported AW (AW <= FWD_RD_W), zero-extended
    localparam int FWD_RD_W = 8;

    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FWD_SELW = fwd_sel_width(FWD_DEPTH);

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [FWD_RD_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forwarding selector: youngest matching stage wins, else register file;
// flags a load-use hazard when the winning producer is a load still in EX.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SELW  = 2
) (
    input  logic [AW-1:0]             src,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [DEPTH-1:0]          sb_valid,
    input  logic [DEPTH-1:0]          sb_wreg,
    input  logic [DEPTH-1:0]          sb_m2reg,
    input  logic [DEPTH*FWD_RD_W-1:0] sb_rd,
    input  logic [DEPTH*XLEN-1:0]     stage_data,
    output logic [SELW-1:0]           sel,
    output logic [XLEN-1:0]           data,
    output logic                      load_hazard
);

    localparam logic [DEPTH-1:0] EX_ONLY = DEPTH'(1);

    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = sb_valid[gi] & sb_wreg[gi]
                             & (sb_rd[gi*FWD_RD_W +: FWD_RD_W] == FWD_RD_W'(src))
                             & (src != '0);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching stage overrides.
    always_comb begin
        sel  = SELW'(FWD_SEL_RF);
        data = rf_data;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel  = SELW'(k + FWD_SEL_STAGE);
                data = stage_data[k*XLEN +: XLEN];
            end
        end
    end

    // A load in MEM or later already has its data on stage_data; only EX stalls.
    assign load_hazard = |(match & sb_m2reg & EX_ONLY);

endmodule

// File: rtl/fwd_bypass_unit.sv
// ID/EX operand forwarding and load-use stall unit with a shifting destination scoreboard.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_bypass_unit
    import fwd_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int AW    = 5,
    parameter  int NSRC  = 2,
    parameter  int DEPTH = FWD_DEPTH,
    localparam int SELW  = fwd_sel_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [NSRC*AW-1:0]    id_src,
    input  logic [NSRC*XLEN-1:0]  id_rf_data,
    input  logic                  id_wreg,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_m2reg,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [NSRC*XLEN-1:0]  ex_operand,
    output logic [NSRC*SELW-1:0]  ex_fwd_sel,
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count
);

    sb_entry_t sb_reg  [DEPTH];
    sb_entry_t sb_next [DEPTH];

    logic [DEPTH-1:0]          sb_valid;
    logic [DEPTH-1:0]          sb_wreg;
    logic [DEPTH-1:0]          sb_m2reg;
    logic [DEPTH*FWD_RD_W-1:0] sb_rd;

    logic [NSRC*SELW-1:0] sel;
    logic [NSRC*XLEN-1:0] data;
    logic [NSRC-1:0]      hazard;
    logic                 issue;

    logic [NSRC*XLEN-1:0] ex_operand_reg;
    logic [NSRC*SELW-1:0] ex_fwd_sel_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb_flat
            assign sb_valid[gi] = sb_reg[gi].valid;
            assign sb_wreg[gi]  = sb_reg[gi].wreg;
            assign sb_m2reg[gi] = sb_reg[gi].m2reg;
            assign sb_rd[gi*FWD_RD_W +: FWD_RD_W] = sb_reg[gi].rd;
        end

        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            fwd_src_sel #(
                .XLEN  (XLEN),
                .AW    (AW),
                .DEPTH (DEPTH),
                .SELW  (SELW)
            ) u_sel (
                .src         (id_src[gi*AW +: AW]),
                .rf_data     (id_rf_data[gi*XLEN +: XLEN]),
                .sb_valid    (sb_valid),
                .sb_wreg     (sb_wreg),
                .sb_m2reg    (sb_m2reg),
                .sb_rd       (sb_rd),
                .stage_data  (stage_data),
                .sel         (sel[gi*SELW +: SELW]),
                .data        (data[gi*XLEN +: XLEN]),
                .load_hazard (hazard[gi])
            );
        end
    endgenerate

    assign stall = id_valid & (|hazard);
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        sb_next[0] = '0;
        if (issue) begin
            sb_next[0].valid = 1'b1;
            sb_next[0].wreg  = id_wreg;
            sb_next[0].m2reg = id_m2reg;
            sb_next[0].rd    = FWD_RD_W'(id_rd);
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_next[k] = sb_reg[k-1];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= '0;
            end
            ex_operand_reg <= '0;
            ex_fwd_sel_reg <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= sb_next[k];
            end
            ex_operand_reg <= issue ? data : '0;
            ex_fwd_sel_reg <= issue ? sel  : '0;
        end
    end

    assign ex_valid   = sb_reg[0].valid;
    assign ex_operand = ex_operand_reg;
    assign ex_fwd_sel = ex_fwd_sel_reg;

`ifdef FWD_PERF_CNT_EN
    localparam int INCW = $clog2(NSRC + 1);

    logic [31:0]     stall_count_reg;
    logic [31:0]     fwd_count_reg;
    logic [INCW-1:0] fwd_inc;
    logic [32:0]     fwd_sum;

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (issue && (sel[i*SELW +: SELW] != SELW'(FWD_SEL_RF))) begin
                fwd_inc = fwd_inc + INCW'(1);
            end
        end
    end

    assign fwd_sum = {1'b0, fwd_count_reg} + 33'(fwd_inc);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_count_reg <= '0;
            fwd_count_reg   <= '0;
        end else if (en) begin
            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            fwd_count_reg <= fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end

    assign stall_count = stall_count_reg;
    assign fwd_count   = fwd_count_reg;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

endmodule
